// File: rtl/gfx_pkg.sv
// gfx_pkg: shared graphics types for the frame-buffer scan-out path.
//   PIX_W / PIX_PER_WORD / WORD_W : pixel and colour-SRAM word geometry
//   rgb_t, word_t                 : pixel and packed-word types
//   fb_state_t                    : scan-out FSM states
//   replicate_rgb()               : fills a packed word with one colour
package gfx_pkg;

  localparam int PIX_W        = 24;
  localparam int PIX_PER_WORD = 16;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int IDX_W        = 4;

  typedef logic [PIX_W-1:0]  rgb_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } fb_state_t;

  function automatic word_t replicate_rgb(input rgb_t c);
    return {PIX_PER_WORD{c}};
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: colour-SRAM port and pixel stream of the scan-out stage.
//   sram_re/sram_addr/sram_rdata : read port, rdata valid the cycle after re
//   sram_we/sram_wdata/clear_rgb : write-back port (FB_SCANOUT_CLEAR_EN only)
//   pix_valid/pix_ready/pix_rgb/pix_sof/pix_eol/pix_last : pixel stream
// Modports: master = scan-out block, slave = SRAM + display side.
//
// Pixel stream handshake: a pixel transfers on every rising edge where
// pix_valid and pix_ready are both high. Once pix_valid is raised it stays
// high, and pix_rgb/pix_sof/pix_eol/pix_last stay stable, until that
// transfer happens. pix_ready may toggle freely and never depends on
// pix_valid.
interface fb_scanout_if #(
  parameter int ADDR_W = 16
);
  import gfx_pkg::*;

  logic              sram_re;
  logic [ADDR_W-1:0] sram_addr;
  word_t             sram_rdata;
`ifdef FB_SCANOUT_CLEAR_EN
  logic              sram_we;
  word_t             sram_wdata;
  rgb_t              clear_rgb;
`endif
  logic              pix_valid;
  logic              pix_ready;
  rgb_t              pix_rgb;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_last;

  modport master (
`ifdef FB_SCANOUT_CLEAR_EN
    output sram_we,
    output sram_wdata,
    input  clear_rgb,
`endif
    output sram_re,
    output sram_addr,
    input  sram_rdata,
    output pix_valid,
    input  pix_ready,
    output pix_rgb,
    output pix_sof,
    output pix_eol,
    output pix_last
  );

  modport slave (
`ifdef FB_SCANOUT_CLEAR_EN
    input  sram_we,
    input  sram_wdata,
    output clear_rgb,
`endif
    input  sram_re,
    input  sram_addr,
    output sram_rdata,
    input  pix_valid,
    output pix_ready,
    input  pix_rgb,
    input  pix_sof,
    input  pix_eol,
    input  pix_last
  );

endinterface

// File: rtl/fb_scanout_pix_serializer.sv
// pix_serializer: two-word pixel buffer for the scan-out stage.
//   H (h_q) is the word being shifted out, P (p_q) the prefetched next word.
//   load/load_data : a word returned from the SRAM; goes to H if H is empty,
//                    otherwise to P
//   pop            : current pixel accepted downstream
//   flush          : drop both words at the start of a new frame
//   h_vld          : H holds a word (drives pixel valid)
//   pix_rgb        : current pixel (low lane of H, a register slice)
//   pix_idx        : lane index of the current pixel, 0..15
//   pix_eol        : registered (pix_idx == 15)
//   empty / full   : neither / both of H and P hold a word
module pix_serializer
  import gfx_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic             load,
  input  word_t            load_data,
  input  logic             pop,
  output logic             h_vld,
  output rgb_t             pix_rgb,
  output logic [IDX_W-1:0] pix_idx,
  output logic             pix_eol,
  output logic             empty,
  output logic             full
);

  word_t h_q;
  word_t p_q;
  logic  p_vld;
  logic  pop_mid;
  logic  pop_last;

  assign pix_rgb  = h_q[PIX_W-1:0];
  assign empty    = !h_vld && !p_vld;
  assign full     = h_vld && p_vld;
  assign pop_mid  = pop && h_vld && (pix_idx != 4'd15);
  assign pop_last = pop && h_vld && (pix_idx == 4'd15);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      h_q     <= '0;
      p_q     <= '0;
      h_vld   <= 1'b0;
      p_vld   <= 1'b0;
      pix_idx <= '0;
      pix_eol <= 1'b0;
    end else if (flush) begin
      h_vld   <= 1'b0;
      p_vld   <= 1'b0;
      pix_idx <= '0;
      pix_eol <= 1'b0;
    end else begin
      // Shifting H right keeps the current pixel in the low lane, so the
      // pixel output is a plain register slice.
      if (pop_mid) begin
        h_q     <= h_q >> PIX_W;
        pix_idx <= pix_idx + 4'd1;
        pix_eol <= (pix_idx == 4'd14);
      end

      // Word boundary: promote P into H with no bubble; if P is not there
      // yet, a word arriving this very cycle goes straight into H,
      // otherwise H empties and the stream stalls until the next load.
      if (pop_last) begin
        pix_idx <= '0;
        pix_eol <= 1'b0;
        if (p_vld) begin
          h_q <= p_q;
        end else if (load) begin
          h_q <= load_data;
        end else begin
          h_vld <= 1'b0;
        end
      end

      if (load) begin
        if (!h_vld) begin
          h_q     <= load_data;
          h_vld   <= 1'b1;
          pix_idx <= '0;
          pix_eol <= 1'b0;
        end else if (!(pop_last && !p_vld)) begin
          p_q   <= load_data;
          p_vld <= 1'b1;
        end
      end

      if (pop_last && p_vld && !load) begin
        p_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: reads a rendered frame from the packed colour SRAM
// (16 pixels per 384-bit word) and streams it one pixel per cycle.
//   clk, srst   : clock, asynchronous active-high reset
//   start       : one-cycle pulse, begins a frame (ignored while busy)
//   bus         : fb_scanout_if.master, SRAM port and pixel stream
//   busy, done  : frame in progress / one-cycle end-of-frame pulse
//   state_dbg   : current FSM state
// Build option FB_SCANOUT_CLEAR_EN: each word is rewritten with 16 copies of
// bus.clear_rgb in the cycle after its read data is captured, leaving the
// frame cleared for the next render. Without it the block is read-only.
module fb_scanout
  import gfx_pkg::*;
#(
  parameter int FRAME_WORDS = 65536,
  parameter int ADDR_W      = 16
) (
  input  logic      clk,
  input  logic      srst,
  input  logic      start,
  fb_scanout_if.master bus,
  output logic      busy,
  output logic      done,
  output fb_state_t state_dbg
);

  localparam logic [ADDR_W:0] FW_P   = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [ADDR_W:0] LAST_P = (ADDR_W+1)'(FRAME_WORDS - 1);

  fb_state_t         state_q;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   out_word;
  logic              rd_inflight;
  logic              re_q;
  logic [ADDR_W-1:0] addr_q;
  logic              sof_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
`ifdef FB_SCANOUT_CLEAR_EN
  logic              we_q;
  word_t             wdata_q;
`endif

  logic             h_vld;
  logic             buf_empty;
  logic             buf_full;
  logic [IDX_W-1:0] pix_idx;
  logic             flush;
  logic             hs;
  logic             room;
  logic             issue_rd;

  assign flush = (state_q == IDLE) && start;
  assign hs    = h_vld && bus.pix_ready;

  // Room for one more word counting the one landing this edge: never more
  // than H plus the single prefetch slot outstanding.
  assign room = buf_empty || (!buf_full && !rd_inflight);

  // One read at a time; with write-back the cycle after a capture belongs
  // to the write, so no read is launched into it.
  assign issue_rd = ((state_q == FILL) || (state_q == STREAM)) &&
                    !re_q && (rd_ptr < FW_P) && room
`ifdef FB_SCANOUT_CLEAR_EN
                    && !rd_inflight
`endif
                    ;

  pix_serializer u_ser (
    .clk       (clk),
    .srst      (srst),
    .flush     (flush),
    .load      (rd_inflight),
    .load_data (bus.sram_rdata),
    .pop       (hs),
    .h_vld     (h_vld),
    .pix_rgb   (bus.pix_rgb),
    .pix_idx   (pix_idx),
    .pix_eol   (bus.pix_eol),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign bus.sram_re   = re_q;
  assign bus.sram_addr = addr_q;
  assign bus.pix_valid = h_vld;
  assign bus.pix_sof   = sof_q;
  assign bus.pix_last  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign state_dbg     = state_q;
`ifdef FB_SCANOUT_CLEAR_EN
  assign bus.sram_we    = we_q;
  assign bus.sram_wdata = wdata_q;
`endif

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q     <= IDLE;
      rd_ptr      <= '0;
      out_word    <= '0;
      rd_inflight <= 1'b0;
      re_q        <= 1'b0;
      addr_q      <= '0;
      sof_q       <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef FB_SCANOUT_CLEAR_EN
      we_q        <= 1'b0;
      wdata_q     <= '0;
`endif
    end else begin
      rd_inflight <= re_q;
      re_q        <= 1'b0;
      done_q      <= 1'b0;
`ifdef FB_SCANOUT_CLEAR_EN
      we_q        <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            // Word 0 is requested straight from the start edge so its
            // data is back two cycles later.
            state_q  <= FILL;
            busy_q   <= 1'b1;
            re_q     <= 1'b1;
            addr_q   <= '0;
            rd_ptr   <= {{ADDR_W{1'b0}}, 1'b1};
            out_word <= '0;
            sof_q    <= 1'b0;
            last_q   <= 1'b0;
          end
        end

        FILL, STREAM: begin
          if (issue_rd) begin
            re_q   <= 1'b1;
            addr_q <= rd_ptr[ADDR_W-1:0];
            rd_ptr <= rd_ptr + 1'b1;
          end
`ifdef FB_SCANOUT_CLEAR_EN
          // addr_q still holds the captured word's address here.
          if (rd_inflight) begin
            we_q    <= 1'b1;
            wdata_q <= replicate_rgb(bus.clear_rgb);
          end
`endif
          if ((state_q == FILL) && rd_inflight) begin
            state_q <= STREAM;
            sof_q   <= 1'b1;
          end
          if (hs) begin
            sof_q <= 1'b0;
            if ((pix_idx == 4'd14) && (out_word == LAST_P)) begin
              last_q <= 1'b1;
            end
            if (pix_idx == 4'd15) begin
              out_word <= out_word + 1'b1;
              if (last_q) begin
                last_q  <= 1'b0;
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed bench for fb_scanout. Two instances share clock
// and reset: dut (FRAME_WORDS=2) and dut1 (FRAME_WORDS=1), each with its own
// SRAM model. Word w, pixel i holds (w << 20) | i.
module tb_fb_scanout;
  import gfx_pkg::*;

  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  logic      start0, start1;
  logic      busy0, busy1, done0, done1;
  fb_state_t st0, st1;

  fb_scanout_if #(.ADDR_W(AW)) b0 ();
  fb_scanout_if #(.ADDR_W(AW)) b1 ();

  fb_scanout #(.FRAME_WORDS(2), .ADDR_W(AW)) dut (
    .clk(clk), .srst(srst), .start(start0), .bus(b0),
    .busy(busy0), .done(done0), .state_dbg(st0)
  );

  fb_scanout #(.FRAME_WORDS(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .srst(srst), .start(start1), .bus(b1),
    .busy(busy1), .done(done1), .state_dbg(st1)
  );

  // ---------------- SRAM models ----------------
  word_t mem0 [2];
  word_t mem1 [1];
  logic  load_req;

  function automatic word_t pattern(input int w);
    word_t x;
    for (int i = 0; i < 16; i++) x[24*i +: 24] = 24'((w << 20) | i);
    return x;
  endfunction

  always @(posedge clk) begin
    if (load_req) begin
      mem0[0] <= pattern(0);
      mem0[1] <= pattern(1);
      mem1[0] <= pattern(0);
    end
    if (b0.sram_re) b0.sram_rdata <= mem0[b0.sram_addr[0]];
    if (b1.sram_re) b1.sram_rdata <= mem1[0];
`ifdef FB_SCANOUT_CLEAR_EN
    if (b0.sram_we) mem0[b0.sram_addr[0]] <= b0.sram_wdata;
    if (b1.sram_we) mem1[0] <= b1.sram_wdata;
`endif
  end

  // ---------------- observation mux ----------------
  logic    sel;
  logic    m_valid, m_sof, m_eol, m_last, m_re, m_busy, m_done;
  rgb_t    m_rgb;
  logic [AW-1:0] m_addr;
  fb_state_t m_st;
  assign m_valid = sel ? b1.pix_valid : b0.pix_valid;
  assign m_sof   = sel ? b1.pix_sof   : b0.pix_sof;
  assign m_eol   = sel ? b1.pix_eol   : b0.pix_eol;
  assign m_last  = sel ? b1.pix_last  : b0.pix_last;
  assign m_rgb   = sel ? b1.pix_rgb   : b0.pix_rgb;
  assign m_re    = sel ? b1.sram_re   : b0.sram_re;
  assign m_addr  = sel ? b1.sram_addr : b0.sram_addr;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;
  assign m_st    = sel ? st1 : st0;
`ifdef FB_SCANOUT_CLEAR_EN
  logic m_we;
  assign m_we = sel ? b1.sram_we : b0.sram_we;
`endif

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_re"},    32'(m_re), 0);
    check({tag, "_addr"},  32'(m_addr), 0);
    check({tag, "_valid"}, 32'(m_valid), 0);
    check({tag, "_rgb"},   32'(m_rgb), 0);
    check({tag, "_flags"}, 32'({m_sof, m_eol, m_last}), 0);
    check({tag, "_busy"},  32'(m_busy), 0);
    check({tag, "_done"},  32'(m_done), 0);
    check({tag, "_state"}, 32'(m_st), 32'(IDLE));
`ifdef FB_SCANOUT_CLEAR_EN
    check({tag, "_we"},    32'(m_we), 0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_mem();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic drive(input bit s, input logic st, input logic rdy);
    if (s) begin
      start1 = st; b1.pix_ready = rdy;
    end else begin
      start0 = st; b0.pix_ready = rdy;
    end
  endtask

  // Runs one frame on instance s from a negedge; cycle 0 carries start.
  task automatic run_frame(input bit s, input bit rnd, input int restart_at);
    logic [26:0]   exp_q[$];
    logic [AW-1:0] addr_log[$];
    logic [26:0]   e, cur_out, prev_out;
    logic          prev_stall, rdy;
    int            nw, npix, cyc, done_cnt, exp_done_cyc, first_valid, reads, words_done;
    sel = s;
    nw = s ? 1 : 2;
    npix = 16 * nw;
    for (int p = 0; p < npix; p++)
      exp_q.push_back({p == 0, (p % 16) == 15, p == npix - 1, 24'(((p / 16) << 20) | (p % 16))});
    cyc = 0; done_cnt = 0; exp_done_cyc = -1; first_valid = -1;
    reads = 0; words_done = 0; prev_stall = 1'b0; prev_out = '0;
    while (cyc < 300 && (exp_q.size() != 0 || cyc <= exp_done_cyc + 3)) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(s, (cyc == 0) || (cyc == restart_at), rdy);
      cur_out = {m_sof, m_eol, m_last, m_rgb};
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_hold", 32'(cur_out), 32'(prev_out));
      end
      if (m_re) begin
        addr_log.push_back(m_addr);
        reads++;
        check("read_ahead", 32'((reads - words_done) <= 2), 1);
      end
`ifdef FB_SCANOUT_CLEAR_EN
      if (m_we) check("we_re_excl", 32'(m_re), 0);
`endif
      if (cyc == 1) check("busy_after_start", 32'(m_busy), 1);
      if (m_done) begin
        done_cnt++;
        check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
        check("busy_at_done", 32'(m_busy), 0);
      end
      if (m_valid && first_valid < 0) begin
        first_valid = cyc;
        check("first_valid_lat", 32'(cyc), 3);
      end
      if (m_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pix_rgb", 32'(m_rgb), 32'(e[23:0]));
          check("pix_flags", 32'({m_sof, m_eol, m_last}), 32'(e[26:24]));
          if (e[24]) exp_done_cyc = cyc + 1;
          if (e[25]) words_done++;
        end
      end
      prev_stall = m_valid && !rdy;
      prev_out = cur_out;
      @(negedge clk);
      cyc++;
    end
    drive(s, 1'b0, 1'b1);
    check("pixels_left", 32'(exp_q.size()), 0);
    check("done_count", 32'(done_cnt), 1);
    check("read_count", 32'(addr_log.size()), 32'(nw));
    for (int i = 0; i < addr_log.size() && i < nw; i++)
      check("read_addr", 32'(addr_log[i]), 32'(i));
    check("idle_after", 32'(m_busy), 0);
  endtask

  task automatic check_cleared(input bit s);
`ifdef FB_SCANOUT_CLEAR_EN
    word_t w;
    for (int k = 0; k < (s ? 1 : 2); k++) begin
      w = s ? mem1[0] : mem0[k];
      for (int i = 0; i < 16; i++) check("cleared_lane", 32'(w[24*i +: 24]), 32'h203040);
    end
`else
    if (s) sel = 1'b1;
`endif
  endtask

  // srst mid-frame while pixel 7 is on the output.
  task automatic abort_test();
    sel = 1'b0;
    b0.pix_ready = 1'b1;
    start0 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    check("abort_pix7_rgb", 32'(b0.pix_rgb), 32'h7);
    #2 srst = 1'b1;
    #1;
    check_outputs_zero("abort");
    @(negedge clk);
    srst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    srst = 1'b1; start0 = 1'b0; start1 = 1'b0; load_req = 1'b0; sel = 1'b0;
    b0.pix_ready = 1'b0; b1.pix_ready = 1'b0;
`ifdef FB_SCANOUT_CLEAR_EN
    b0.clear_rgb = 24'h203040; b1.clear_rgb = 24'h203040;
`endif
    repeat (2) @(negedge clk);
    sel = 1'b0; check_outputs_zero("reset0");
    sel = 1'b1; check_outputs_zero("reset1");
    srst = 1'b0;

    load_mem(); run_frame(1'b0, 1'b0, -1); check_cleared(1'b0);
    load_mem(); run_frame(1'b0, 1'b1, -1); check_cleared(1'b0);
    load_mem(); run_frame(1'b0, 1'b0, 8);
    load_mem(); abort_test();
    load_mem(); run_frame(1'b0, 1'b0, -1);
    load_mem(); run_frame(1'b1, 1'b0, -1); check_cleared(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Frame-buffer scan-out stage downstream of the 3D-to-2D rendering top. After rendering finishes, it reads the packed colour SRAM (16 RGB pixels per 384-bit word) and serialises the frame as a one-pixel-per-cycle valid/ready stream for the display/host link. It prefetches one word ahead so the stream sustains one pixel per cycle with no bubbles.

## Interface
- FRAME_WORDS, 65536: number of colour SRAM words per frame (16 pixels each)
- ADDR_W, 16: colour SRAM address width; FRAME_WORDS ≤ 2^ADDR_W
- clk  in  1  single clock, rising edge
- srst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins scan-out of a frame (driven from render `finish`)
- sram_re  out  1  colour SRAM read strobe
- sram_addr  out  ADDR_W  colour SRAM word address
- sram_rdata  in  384  read data, valid in the cycle after sram_re; pixel i = bits [24i+23:24i]
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accept
- pix_rgb  out  24  pixel R[23:16] G[15:8] B[7:0]
- pix_sof  out  1  high with first pixel of frame
- pix_eol  out  1  high with last pixel of each word (pixel 15)
- pix_last  out  1  high with final pixel of frame
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after final pixel handshake

## Operation
- FSM states: IDLE, FILL, STREAM, DONE.
- IDLE: on start, enter FILL; word counter rd_ptr=0.
- FILL: issue read of word 0; capture into holding register H; enter STREAM.
- STREAM: H shifts out pixel 0..15; pixel index pix_idx (4 bit) advances on each handshake (pix_valid & pix_ready).
- Prefetch register P with flag p_vld: a read is issued whenever p_vld=0, no read is in flight, and rd_ptr<FRAME_WORDS. The word is captured into P.
- On handshake of pixel 15: if p_vld, H←P and p_vld←0 in the same cycle; pix_valid stays high. If P is not ready, pix_valid drops until capture (stall; this must not occur with a 1-cycle SRAM).
- Final pixel handshake (word FRAME_WORDS-1, pixel 15): enter DONE. DONE pulses done for one cycle, then returns to IDLE.
- start while busy: ignored.
- pix_ready low: pix_rgb, pix_sof, pix_eol and pix_last hold stable; prefetch continues up to the single P slot.
- rd_ptr is ADDR_W+1 bits; no wrap. Reads stop at FRAME_WORDS.

## Timing
- Reset values: sram_re=0, sram_addr=0, pix_valid=0, pix_rgb=0, pix_sof=0, pix_eol=0, pix_last=0, busy=0, done=0. Reset mid-frame aborts immediately to IDLE; in-flight read data is discarded.
- start sampled at edge t. At t+1: sram_re=1, addr=0, busy=1. At t+2: rdata valid. At t+3: pix_valid=1 with pixel 0 and pix_sof=1.
- Second word is read at t+3 and captured at t+4, well before pixel 15.
- With pix_ready held high: 16·FRAME_WORDS consecutive valid cycles. done pulses the cycle after the final handshake; busy falls in the same cycle.
- All outputs are registered.

## Configuration
- FB_SCANOUT_CLEAR_EN defined: adds ports clear_rgb (in, 24), sram_we (out, 1) and sram_wdata (out, 384). In the cycle after a word's read data is captured, the block writes 16 copies of clear_rgb to that same address, with sram_re=0 during the write. No read is issued in a write cycle. The frame is therefore cleared for the next render. Start→first valid latency is unchanged.
- FB_SCANOUT_CLEAR_EN undefined: these ports are absent; the block is read-only.

## Structure
- Shared package `gfx_pkg`: PIX_W=24, PIX_PER_WORD=16, WORD_W=384, an rgb_t typedef, and FSM state enum fb_state_t.
- One sub-module, `pix_serializer`: holds H and P, exposes word load and pixel pop, and generates pix_idx, pix_eol and the empty/full flags. The top holds the FSM, the read/write sequencing and the pointers.

## Test plan
- FRAME_WORDS=2, pix_ready=1, SRAM word0 pixel i=0x000000+i, word1 pixel i=0x100000+i → 32 consecutive pixels in order; pix_sof on pixel 0; pix_eol on pixels 15 and 31; pix_last on pixel 31; done at the following cycle; first valid 3 cycles after start.
- Same frame, pix_ready random 50% → identical pixel sequence; outputs stable while stalled; at most one read ahead (sram_re never asserted while p_vld=1).
- start pulsed again mid-frame → ignored; sram_addr sequence stays 0,1; exactly one done.
- srst asserted asynchronously at pixel 7 → all outputs 0 immediately; a new start afterwards yields a full correct frame from pixel 0.
- FB_SCANOUT_CLEAR_EN, clear_rgb=0x203040 → after the frame, both SRAM words read 0x203040 in all 16 lanes; streamed pixels equal the original contents; sram_we and sram_re are never high together.
- FRAME_WORDS=1 → 16 pixels, with pix_sof on pixel 0 and pix_last on pixel 15; exactly one sram_re.
